id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL: flush  input  1  branch/jump taken; current ID instruction is wrong-path.
REQ-004 SHALL: id_valid  input  1  ID holds a real instruction.
REQ-005 SHALL: id_opcode  input  4  decoded opcode.
REQ-006 SHALL: id_rs, id_rt, id_rd  input  4 each  source and destination register addresses.
REQ-007 SHALL: id_rs_used, id_rt_used  input  1 each  instruction actually reads rs/rt.
REQ-008 SHALL: id_ctrl  input  6  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, hlt}.
REQ-009 SHALL: id_rs_data, id_rt_data, id_imm, id_pc1  input  16 each  operands, immediate, PC+1.
REQ-010 SHALL: ex_valid, ex_opcode, ex_rs, ex_rt, ex_rd, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_pc1  output  same widths  registered ID/EX contents; ex_rs/ex_rt/ex_opcode/ex_ctrl[5] drive forwarding control.
REQ-011 SHALL: stall  output  1  hold PC and IF/ID this cycle.
REQ-012 SHALL: stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-013 SHALL assert stall combinationally (0 latency) when ex_valid & ex_ctrl.mem_read & ex_rd!=0 & id_valid & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)), and flush=0.
REQ-014 SHALL never assert stall while flush=1 (flush wins).
REQ-015 SHALL, per rising edge, update with priority rst > flush > stall > load.
REQ-016 SHALL on flush or stall load a bubble: ex_valid=0, ex_ctrl=0, all other ex_* fields 0.
REQ-017 SHALL on load copy every id_* field to its ex_* counterpart in one cycle; ex_valid=id_valid; if id_valid=0, ex_ctrl SHALL be 0.
REQ-018 SHALL insert exactly one bubble per load-use hazard: after the bubble, ex_ctrl.mem_read=0, so stall deasserts and the held instruction loads next edge.
REQ-019 SHALL treat register 0 as never-hazardous (ex_rd==0 never stalls).
REQ-020 SHALL increment stall_cnt on each edge where stall=1 and rst=0, saturating at 16'hFFFF.
REQ-021 SHALL increment flush_cnt on each edge where flush=1 and rst=0, saturating at 16'hFFFF.
REQ-022 SHALL keep counters at 16'hFFFF once reached; no wrap-around.
REQ-023 SHALL treat simultaneous flush and load-use condition as flush only: one bubble, flush_cnt+1, stall_cnt unchanged.

Reset
REQ-024 SHALL on rst=1 at an edge clear every ex_* output, stall_cnt and flush_cnt to 0, regardless of flush/stall.
REQ-025 SHALL hold stall=0 while reset state persists (ex_valid=0 after reset).
REQ-026 SHALL abort any in-progress stall when rst asserts mid-hazard; first post-reset cycle behaves as empty pipeline.

Structure
REQ-027 SHALL take DATA_W=16, REG_W=4, OPC_W=4, CTRL_W=6 and named ctrl bit indices from shared package cpu_pkg.
REQ-028 SHALL place the REQ-013 compare in one combinational sub-module hazard_detect; registers and counters in id_ex_stage.

Verification
REQ-029 SHALL cover: load r3 in EX (ex_ctrl.mem_read=1, ex_rd=3), ID add reads rs=3 -> stall=1 one cycle, bubble in EX, add loads next edge, stall_cnt=1.
REQ-030 SHALL cover: same as REQ-029 but ex_rd=0, or id_rs_used=0 -> stall=0, no bubble.
REQ-031 SHALL cover: hazard condition with flush=1 -> stall=0, ex_valid=0 next cycle, flush_cnt=1, stall_cnt=0.
REQ-032 SHALL cover: preload stall_cnt to 16'hFFFE via 2^16-2 hazards, two more -> stall_cnt=16'hFFFF, stays.
REQ-033 SHALL cover: rst=1 during stall with valid ID data -> all ex_* and counters 0 next edge, stall=0.
REQ-034 SHALL cover: normal load id_rs_data=16'hBEEF, id_imm=16'h0005, id_ctrl=6'b100010 -> identical ex_* values one cycle later.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, control-bit indices and ID/EX record for the pipeline
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int OPC_W  = 4;
  localparam int CTRL_W = 6;

  // id_ctrl / ex_ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, hlt}
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_ALU_SRC    = 1;
  localparam int CTRL_HLT        = 0;

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc1;
  } id_ex_t;

  function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs and registered execute-side outputs of the ID/EX stage
interface id_ex_if;
  import cpu_pkg::*;

  logic              id_valid;
  logic [OPC_W-1:0]  id_opcode;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc1;

  logic              ex_valid;
  logic [OPC_W-1:0]  ex_opcode;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc1;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
           id_ctrl, id_rs_data, id_rt_data, id_imm, id_pc1,
    input  ex_valid, ex_opcode, ex_rs, ex_rt, ex_rd, ex_ctrl,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc1
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
           id_ctrl, id_rs_data, id_rt_data, id_imm, id_pc1,
    output ex_valid, ex_opcode, ex_rs, ex_rt, ex_rd, ex_ctrl,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc1
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - load-use hazard compare between the EX load and the ID reader
module hazard_detect
  import cpu_pkg::*;
(
  input  logic             i_flush,
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_rs_used,
  input  logic             i_id_rt_used,
  output logic             o_stall
);

  logic w_ex_is_load;
  logic w_rs_hit;
  logic w_rt_hit;

  // r0 is hardwired zero, so a load targeting it can never feed a reader
  assign w_ex_is_load = i_ex_valid && i_ex_mem_read && (i_ex_rd != '0);
  assign w_rs_hit     = i_id_rs_used && (i_id_rs == i_ex_rd);
  assign w_rt_hit     = i_id_rt_used && (i_id_rt == i_ex_rd);
  assign o_stall      = !i_flush && w_ex_is_load && i_id_valid && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and event counters
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_ex_if.slave           bus,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  id_ex_t           r_ex;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall;

  hazard_detect u_hazard (
    .i_flush      (flush),
    .i_ex_valid   (r_ex.valid),
    .i_ex_mem_read(is_load(r_ex.ctrl)),
    .i_ex_rd      (r_ex.rd),
    .i_id_valid   (bus.id_valid),
    .i_id_rs      (bus.id_rs),
    .i_id_rt      (bus.id_rt),
    .i_id_rs_used (bus.id_rs_used),
    .i_id_rt_used (bus.id_rt_used),
    .o_stall      (w_stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (flush || w_stall) begin
        r_ex <= '0;
      end else begin
        r_ex.valid   <= bus.id_valid;
        r_ex.opcode  <= bus.id_opcode;
        r_ex.rs      <= bus.id_rs;
        r_ex.rt      <= bus.id_rt;
        r_ex.rd      <= bus.id_rd;
        r_ex.ctrl    <= bus.id_valid ? bus.id_ctrl : '0;
        r_ex.rs_data <= bus.id_rs_data;
        r_ex.rt_data <= bus.id_rt_data;
        r_ex.imm     <= bus.id_imm;
        r_ex.pc1     <= bus.id_pc1;
      end
      // w_stall is already masked by flush, so the two counters never step together
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall          = w_stall;
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;
  assign bus.ex_valid   = r_ex.valid;
  assign bus.ex_opcode  = r_ex.opcode;
  assign bus.ex_rs      = r_ex.rs;
  assign bus.ex_rt      = r_ex.rt;
  assign bus.ex_rd      = r_ex.rd;
  assign bus.ex_ctrl    = r_ex.ctrl;
  assign bus.ex_rs_data = r_ex.rs_data;
  assign bus.ex_rt_data = r_ex.rt_data;
  assign bus.ex_imm     = r_ex.imm;
  assign bus.ex_pc1     = r_ex.pc1;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage: vector table, corner sequences, random vs model
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall;
  logic        stall2;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [3:0]  stall_cnt2;
  logic [3:0]  flush_cnt2;

  id_ex_if bus();
  id_ex_if bus2();

  assign bus2.id_valid   = bus.id_valid;
  assign bus2.id_opcode  = bus.id_opcode;
  assign bus2.id_rs      = bus.id_rs;
  assign bus2.id_rt      = bus.id_rt;
  assign bus2.id_rd      = bus.id_rd;
  assign bus2.id_rs_used = bus.id_rs_used;
  assign bus2.id_rt_used = bus.id_rt_used;
  assign bus2.id_ctrl    = bus.id_ctrl;
  assign bus2.id_rs_data = bus.id_rs_data;
  assign bus2.id_rt_data = bus.id_rt_data;
  assign bus2.id_imm     = bus.id_imm;
  assign bus2.id_pc1     = bus.id_pc1;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // narrow-counter copy so saturation of the stall counter is reachable quickly
  id_ex_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2),
    .stall(stall2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit valid;
    int opcode, rs, rt, rd, ctrl, rs_data, rt_data, imm, pc1;
  } ex_model_t;

  ex_model_t m_ex;
  int        m_scnt, m_fcnt, m_scnt2, m_fcnt2;
  logic      s_stall;

  typedef struct {
    bit          flush;
    bit          valid;
    logic [3:0]  opc, rs, rt, rd;
    bit          rsu, rtu;
    logic [5:0]  ctrl;
    logic [15:0] rs_data, rt_data, imm, pc1;
    bit          e_stall;
    bit          e_valid;
    logic [5:0]  e_ctrl;
    logic [15:0] e_rs_data, e_imm;
    int          e_scnt, e_fcnt;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_id(input bit v, input int opc, rs, rt, rd, input bit rsu, rtu,
                        input int ctrl, rs_data, rt_data, imm, pc1);
    bus.id_valid   = v;
    bus.id_opcode  = 4'(opc);
    bus.id_rs      = 4'(rs);
    bus.id_rt      = 4'(rt);
    bus.id_rd      = 4'(rd);
    bus.id_rs_used = rsu;
    bus.id_rt_used = rtu;
    bus.id_ctrl    = 6'(ctrl);
    bus.id_rs_data = 16'(rs_data);
    bus.id_rt_data = 16'(rt_data);
    bus.id_imm     = 16'(imm);
    bus.id_pc1     = 16'(pc1);
  endtask

  // load-use rule: EX holds a valid load to a nonzero register that the ID instruction reads
  function automatic bit model_hazard();
    bit ex_load;
    bit reads;
    ex_load = m_ex.valid && m_ex.ctrl[4] && (m_ex.rd != 0);
    reads   = (bus.id_rs_used && (int'(bus.id_rs) == m_ex.rd)) ||
              (bus.id_rt_used && (int'(bus.id_rt) == m_ex.rd));
    return !flush && bus.id_valid && ex_load && reads;
  endfunction

  task automatic compare_outputs();
    check("ex_valid",   bus.ex_valid,   m_ex.valid);
    check("ex_opcode",  bus.ex_opcode,  m_ex.opcode);
    check("ex_rs",      bus.ex_rs,      m_ex.rs);
    check("ex_rt",      bus.ex_rt,      m_ex.rt);
    check("ex_rd",      bus.ex_rd,      m_ex.rd);
    check("ex_ctrl",    bus.ex_ctrl,    m_ex.ctrl);
    check("ex_rs_data", bus.ex_rs_data, m_ex.rs_data);
    check("ex_rt_data", bus.ex_rt_data, m_ex.rt_data);
    check("ex_imm",     bus.ex_imm,     m_ex.imm);
    check("ex_pc1",     bus.ex_pc1,     m_ex.pc1);
    check("stall_cnt",  stall_cnt,  m_scnt);
    check("flush_cnt",  flush_cnt,  m_fcnt);
    check("stall_cnt_small", stall_cnt2, m_scnt2);
    check("flush_cnt_small", flush_cnt2, m_fcnt2);
  endtask

  task automatic cycle();
    bit        exp_stall;
    ex_model_t nxt;
    #2;
    exp_stall = model_hazard();
    s_stall   = stall;
    check("stall", stall, exp_stall);
    check("stall_small", stall2, exp_stall);
    nxt = '{default: 0};
    if (rst) begin
      m_scnt = 0; m_fcnt = 0; m_scnt2 = 0; m_fcnt2 = 0;
    end else begin
      if (!(flush || exp_stall)) begin
        nxt.valid   = bus.id_valid;
        nxt.opcode  = bus.id_opcode;
        nxt.rs      = bus.id_rs;
        nxt.rt      = bus.id_rt;
        nxt.rd      = bus.id_rd;
        nxt.ctrl    = bus.id_valid ? int'(bus.id_ctrl) : 0;
        nxt.rs_data = bus.id_rs_data;
        nxt.rt_data = bus.id_rt_data;
        nxt.imm     = bus.id_imm;
        nxt.pc1     = bus.id_pc1;
      end
      if (exp_stall) begin
        if (m_scnt < 65535) m_scnt++;
        if (m_scnt2 < 15) m_scnt2++;
      end
      if (flush) begin
        if (m_fcnt < 65535) m_fcnt++;
        if (m_fcnt2 < 15) m_fcnt2++;
      end
    end
    @(posedge clk);
    m_ex = nxt;
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0,1,4'h2,4'h1,4'h2,4'h5,1,1,6'b100010,16'hBEEF,16'h1234,16'h0005,16'h0010, 0,1,6'b100010,16'hBEEF,16'h0005,0,0};
    vecs[1]  = '{0,1,4'h8,4'h1,4'h0,4'h3,1,0,6'b110010,16'h0100,16'h0000,16'h0004,16'h0011, 0,1,6'b110010,16'h0100,16'h0004,0,0};
    vecs[2]  = '{0,1,4'h2,4'h3,4'h4,4'h6,1,1,6'b100000,16'h0AAA,16'h0BBB,16'h0000,16'h0012, 1,0,6'b000000,16'h0000,16'h0000,1,0};
    vecs[3]  = '{0,1,4'h2,4'h3,4'h4,4'h6,1,1,6'b100000,16'h0AAA,16'h0BBB,16'h0000,16'h0012, 0,1,6'b100000,16'h0AAA,16'h0000,1,0};
    vecs[4]  = '{0,1,4'h8,4'h2,4'h0,4'h0,1,0,6'b110010,16'h0200,16'h0000,16'h0008,16'h0013, 0,1,6'b110010,16'h0200,16'h0008,1,0};
    vecs[5]  = '{0,1,4'h2,4'h0,4'h0,4'h9,1,1,6'b100000,16'h0300,16'h0301,16'h0000,16'h0014, 0,1,6'b100000,16'h0300,16'h0000,1,0};
    vecs[6]  = '{0,1,4'h8,4'h1,4'h0,4'h7,1,0,6'b110010,16'h0400,16'h0000,16'h000C,16'h0015, 0,1,6'b110010,16'h0400,16'h000C,1,0};
    vecs[7]  = '{0,1,4'h3,4'h7,4'h2,4'h5,0,1,6'b100010,16'h0500,16'h0501,16'h0007,16'h0016, 0,1,6'b100010,16'h0500,16'h0007,1,0};
    vecs[8]  = '{0,1,4'h8,4'h1,4'h0,4'h8,1,0,6'b110010,16'h0600,16'h0000,16'h0010,16'h0017, 0,1,6'b110010,16'h0600,16'h0010,1,0};
    vecs[9]  = '{1,1,4'h2,4'h1,4'h8,4'h5,1,1,6'b100000,16'h0700,16'h0701,16'h0000,16'h0018, 0,0,6'b000000,16'h0000,16'h0000,1,1};
    vecs[10] = '{0,0,4'h2,4'h8,4'h8,4'h5,1,1,6'b100000,16'h0800,16'h0000,16'h0009,16'h0019, 0,0,6'b000000,16'h0800,16'h0009,1,1};

    rst = 1'b1;
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    m_ex = '{default: 0};
    m_scnt = 0; m_fcnt = 0; m_scnt2 = 0; m_fcnt2 = 0;
    compare_outputs();
    check("reset_stall", stall, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      flush = vecs[i].flush;
      set_id(vecs[i].valid, vecs[i].opc, vecs[i].rs, vecs[i].rt, vecs[i].rd,
             vecs[i].rsu, vecs[i].rtu, vecs[i].ctrl, vecs[i].rs_data,
             vecs[i].rt_data, vecs[i].imm, vecs[i].pc1);
      cycle();
      check($sformatf("vec%0d_stall", i), s_stall, vecs[i].e_stall);
      check($sformatf("vec%0d_ex_valid", i), bus.ex_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_ex_ctrl", i), bus.ex_ctrl, vecs[i].e_ctrl);
      check($sformatf("vec%0d_ex_rs_data", i), bus.ex_rs_data, vecs[i].e_rs_data);
      check($sformatf("vec%0d_ex_imm", i), bus.ex_imm, vecs[i].e_imm);
      check($sformatf("vec%0d_stall_cnt", i), stall_cnt, vecs[i].e_scnt);
      check($sformatf("vec%0d_flush_cnt", i), flush_cnt, vecs[i].e_fcnt);
    end
    flush = 1'b0;

    // reset arriving while a load-use stall is pending
    do_reset();
    set_id(1, 8, 1, 0, 3, 1, 0, 6'b110010, 16'h1111, 0, 4, 16'h0020);
    cycle();
    set_id(1, 2, 3, 4, 6, 1, 1, 6'b100000, 16'h2222, 16'h3333, 0, 16'h0021);
    #2;
    check("pre_rst_stall", stall, 1);
    rst = 1'b1;
    cycle();
    check("rst_mid_ex_valid", bus.ex_valid, 0);
    check("rst_mid_ex_rs_data", bus.ex_rs_data, 0);
    check("rst_mid_stall_cnt", stall_cnt, 0);
    check("rst_mid_flush_cnt", flush_cnt, 0);
    check("rst_mid_stall_after", stall, 0);
    rst = 1'b0;
    cycle();
    check("post_rst_stall", s_stall, 0);
    check("post_rst_load_valid", bus.ex_valid, 1);
    check("post_rst_load_rs_data", bus.ex_rs_data, 16'h2222);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 5) == 0);
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 65535),
             $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
      cycle();
    end
    rst = 1'b0;
    flush = 1'b0;

    // a load of r3 that itself reads r3 stalls on every other edge
    do_reset();
    set_id(1, 8, 3, 0, 3, 1, 0, 6'b110010, 16'h4444, 0, 1, 16'h0030);
    repeat (1 + 2 * 14) cycle();
    check("sat_small_14", stall_cnt2, 14);
    check("sat_main_14", stall_cnt, 14);
    repeat (4) cycle();
    check("sat_small_reach", stall_cnt2, 15);
    repeat (4) cycle();
    check("sat_small_hold", stall_cnt2, 15);
    check("sat_main_18", stall_cnt, 18);

    do_reset();
    flush = 1'b1;
    repeat (65534) cycle();
    check("flush_cnt_fffe", flush_cnt, 16'hFFFE);
    cycle();
    check("flush_cnt_ffff", flush_cnt, 16'hFFFF);
    repeat (2) cycle();
    check("flush_cnt_hold", flush_cnt, 16'hFFFF);
    check("flush_stall_cnt_zero", stall_cnt, 0);
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
